// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: text-segment bounds, reset PC, NOP and the
// fetch state encoding used by fetch_ctrl.
package mips_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
   localparam logic [31:0] TEXT_BASE        = 32'h0000_3000;
   localparam logic [31:0] TEXT_END         = 32'h0000_6FFC;
   localparam logic [31:0] NOP              = 32'h0000_0000;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_HOLD = 2'd2
   } fetch_state_t;

   // Address error on fetch: misaligned word or outside the text segment.
   function automatic logic pc_illegal(input logic [31:0] pc);
      return (pc[1:0] != 2'b00) || (pc < TEXT_BASE) || (pc > TEXT_END);
   endfunction

endpackage

// File: rtl/fetch_redir_buf.sv
// Holds a redirect that arrived while a fetch was in flight and selects the
// next fetch PC: live redirect, then buffered redirect, then sequential PC.
module fetch_redir_buf
   import mips_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              redir_valid,
   input  logic [ADDR_W-1:0] redir_target,
   input  logic              in_req,
   input  logic              ack,
   input  logic [ADDR_W-1:0] pc_q,
   output logic [ADDR_W-1:0] next_pc
);

   logic              redir_pend;
   logic [ADDR_W-1:0] redir_tgt_q;

   // A redirect coincident with the ack is used directly, so it never sets pend;
   // a later redirect while pend is set simply overwrites the target.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         redir_pend  <= 1'b0;
         redir_tgt_q <= '0;
      end else if (ack) begin
         redir_pend  <= 1'b0;
      end else if (in_req && redir_valid) begin
         redir_pend  <= 1'b1;
         redir_tgt_q <= redir_target;
      end
   end

   always_comb begin
      next_pc = pc_q + ADDR_W'(4);
      if (redir_valid)
         next_pc = redir_target;
      else if (redir_pend)
         next_pc = redir_tgt_q;
   end

endmodule

// File: rtl/fetch_ctrl.sv
// F-stage PC sequencer: owns pc_q, runs the imem handshake and holds the
// fetched word for D. Optional fetch address-error check under FETCH_ADEL_EN.
module fetch_ctrl
   import mips_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall_i,
   input  logic              redir_valid,
   input  logic [ADDR_W-1:0] redir_target,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ready,
   input  logic [31:0]       imem_rdata,
   output logic              F_valid,
   output logic [ADDR_W-1:0] F_pc,
   output logic [31:0]       F_instr,
   output logic [ADDR_W-1:0] F_pc_add_4,
`ifdef FETCH_ADEL_EN
   output logic              exc_adel,
`endif
   output fetch_state_t      state_dbg
);

   // imem handshake: imem_req stays high with imem_addr stable until a cycle
   // with imem_ready; that cycle transfers imem_rdata. Dropping req without an
   // ack (reset) abandons the request. F side: F_valid marks a held word; D
   // consumes it in any F_valid cycle with stall_i low.

   fetch_state_t      state, state_d;
   logic [ADDR_W-1:0] pc_q, fpc_q, next_pc;
   logic [31:0]       instr_q;
   logic              ack;
   logic              adel;
   logic              adel_q;

`ifdef FETCH_ADEL_EN
   assign adel = (state == S_REQ) && pc_illegal(32'(pc_q));
`else
   assign adel = 1'b0;
`endif

   // An illegal PC completes the fetch locally without touching memory.
   assign ack = (state == S_REQ) && (imem_ready || adel);

   fetch_redir_buf #(.ADDR_W(ADDR_W)) u_redir_buf (
      .clk          (clk),
      .reset        (reset),
      .redir_valid  (redir_valid),
      .redir_target (redir_target),
      .in_req       (state == S_REQ),
      .ack          (ack),
      .pc_q         (pc_q),
      .next_pc      (next_pc)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= S_IDLE;
      else
         state <= state_d;
   end

   always_comb begin
      state_d  = state;
      imem_req = 1'b0;
      F_valid  = 1'b0;
      case (state)
         S_IDLE: state_d = S_REQ;
         S_REQ: begin
            imem_req = !adel;
            if (ack)
               state_d = S_HOLD;
         end
         S_HOLD: begin
            F_valid = 1'b1;
            if (!stall_i)
               state_d = S_REQ;
         end
         default: state_d = S_IDLE;
      endcase
      if (reset) begin
         imem_req = 1'b0;
         F_valid  = 1'b0;
      end
   end

   // Outside S_REQ the current pc_q has not been issued, so a redirect simply
   // replaces it; the held instruction is the delay slot and survives.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q    <= RESET_PC;
         fpc_q   <= '0;
         instr_q <= NOP;
         adel_q  <= 1'b0;
      end else if (ack) begin
         pc_q    <= next_pc;
         fpc_q   <= pc_q;
         instr_q <= adel ? NOP : imem_rdata;
         adel_q  <= adel;
      end else if (redir_valid && (state != S_REQ)) begin
         pc_q    <= redir_target;
      end
   end

   assign imem_addr  = pc_q;
   assign F_pc       = fpc_q;
   assign F_instr    = instr_q;
   assign F_pc_add_4 = fpc_q + ADDR_W'(4);
   assign state_dbg  = state;

`ifdef FETCH_ADEL_EN
   assign exc_adel = F_valid && adel_q;
`else
   logic unused_adel;
   assign unused_adel = adel_q;
`endif

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sequences the F-stage program counter for the 5-stage MIPS pipeline.
- Owns the PC register and drives the instruction-memory request/ready handshake.
- Accepts D-stage redirects (branch/jump targets from the next-PC logic) with delay-slot semantics, honours hazard-unit stalls, and presents the F/D interface (F_pc, F_instr, F_valid).

Parameters:
- RESET_PC, 32'h0000_3000, first fetch address after reset.
- ADDR_W, 32, PC/address width.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- stall_i  in  1  hazard-unit stall; D will not consume F this cycle
- redir_valid  in  1  one-cycle pulse: D-stage branch taken or jump
- redir_target  in  ADDR_W  redirect target, valid with redir_valid
- imem_req  out  1  instruction-memory request
- imem_addr  out  ADDR_W  request address (= pc_q)
- imem_ready  in  1  memory returns data this cycle
- imem_rdata  in  32  instruction word, valid with imem_ready
- F_valid  out  1  F_instr/F_pc hold a fetched instruction
- F_pc  out  ADDR_W  PC of the held instruction
- F_instr  out  32  held instruction word
- F_pc_add_4  out  ADDR_W  F_pc + 4, for D-stage link and next-PC use

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-high; ports are named clk and reset.
- Registers: pc_q, fpc_q, instr_q, redir_pend, redir_tgt_q, state.
- Reset values: pc_q=RESET_PC, fpc_q=0, instr_q=0, redir_pend=0, state=S_IDLE.
- Outputs under reset: imem_req=0 and F_valid=0, combinationally, from reset assertion onward.
- States:
  - S_IDLE: no request. Next cycle goes to S_REQ.
  - S_REQ: imem_req=1, imem_addr=pc_q. Hold until imem_ready.
    - On ready: instr_q<=imem_rdata, fpc_q<=pc_q, pc_q<=next_pc, go to S_HOLD.
  - S_HOLD: F_valid=1, imem_req=0.
    - If !stall_i, D consumes this cycle; go to S_REQ.
    - If stall_i, hold all F outputs unchanged.
- next_pc priority:
  - redir_valid this cycle: redir_target.
  - else redir_pend: redir_tgt_q.
  - else pc_q+4.
  - Clear redir_pend when it is consumed.
- Delay slot: the fetch in flight or held when a redirect arrives is the delay slot and is never killed.
  - Redirect in S_REQ: latch redir_pend=1 and redir_tgt_q=redir_target. The target is applied at the ack.
  - Redirect coincident with ack: target is used directly and pend is not set.
  - Redirect in S_IDLE/S_HOLD: pc_q is not yet issued, so pc_q<=redir_target directly.
- Second redirect while pend is set: later target overwrites the earlier one. This is illegal upstream and is not flagged in RTL.
- Arithmetic: all PC math is modulo 2^ADDR_W. 32'hFFFF_FFFC+4 wraps to 0.
- F_pc_add_4 = fpc_q+4, combinational.
- Stall while in S_REQ: the request continues and the ack is captured. The stall only blocks leaving S_HOLD.
- Reset mid-handshake: the outstanding request is abandoned. Memory must tolerate req dropping without an ack.
- Minimum cadence: 2 cycles per instruction with a zero-wait-state memory (S_REQ, S_HOLD).

Optional Feature:
- Macro: FETCH_ADEL_EN.
- With the macro: extra output exc_adel (1 bit).
  - Illegal PC: pc_q[1:0]!=0 or pc_q outside [32'h3000, 32'h6FFC].
  - On entering S_REQ with an illegal pc_q, assert no imem_req. Go straight to S_HOLD with instr_q=0 (nop), fpc_q=pc_q, exc_adel=1.
  - exc_adel is held with F_valid and is 0 otherwise.
- Without the macro: no exc_adel port and no range checks. Misaligned addresses go to memory as-is.

Decomposition:
- Shared package mips_pkg holds:
  - RESET_PC default, TEXT_BASE=32'h3000, TEXT_END=32'h6FFC.
  - The fetch state enum (S_IDLE, S_REQ, S_HOLD).
  - NOP encoding 32'h0.
- Sub-module fetch_redir_buf: the redir_pend/redir_tgt_q holding register plus the next_pc mux. Everything else stays flat in fetch_ctrl.

Test Plan:
- Reset release, zero-wait memory returning 32'h2408_0001 at 0x3000 → imem_addr 0x3000 and 0x3004 on consecutive S_REQ cycles. F_valid pulses every 2nd cycle, F_pc=0x3000 then 0x3004.
- 3-wait-state memory with stall_i=1 for 4 cycles in S_HOLD → F_pc/F_instr stable throughout. Next request to 0x3008 is issued only on the first !stall_i cycle.
- redir_valid with target 0x3100 in S_REQ at pc 0x3010 → delay slot 0x3010 is delivered, next imem_addr=0x3100.
- Redirect coincident with imem_ready, and redirect in S_HOLD with pc_q=0x3014, target 0x3200 → next fetch 0x3200 in both cases, no extra 0x3014 fetch.
- Assert reset during S_REQ at 0x3020 → imem_req=0 and F_valid=0 immediately. After release, first fetch is 0x3000.
- With FETCH_ADEL_EN, redirect to 0x3102 → no imem_req for it. F_valid=1, F_instr=0, F_pc=0x3102, exc_adel=1.
